// File: rtl/sub_serial_16bit_pkg.sv
// Shared definitions for the lane-serial saturating subtractor:
// FSM encoding, lane count and saturation constants.
package sub_serial_16bit_pkg;
    localparam int SSUB_LANES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] SAT_POS16 = 16'h7FFF;
    localparam logic [15:0] SAT_NEG16 = 16'h8000;
    localparam logic [3:0]  SAT_POS4  = 4'h7;
    localparam logic [3:0]  SAT_NEG4  = 4'h8;
endpackage

// File: rtl/sub_serial_16bit_lane.sv
// Combinational 4-bit lane: a + ~b + cin, with carry-out and signed overflow.
module sub_lane_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] diff,
    output logic       cout,
    output logic       ovf
);
    logic [4:0] sum;

    always_comb begin
        sum  = {1'b0, a} + {1'b0, ~b} + {4'b0000, cin};
        diff = sum[3:0];
        cout = sum[4];
        // Operands of differing sign whose result sign departs from the minuend
        ovf  = (a[3] != b[3]) && (sum[3] != a[3]);
    end
endmodule

// File: rtl/sub_serial_16bit.sv
// 16-bit saturating subtractor processing one 4-bit lane per cycle,
// either as a carry-chained 16-bit op (mode 0) or four independent lanes (mode 1).
module sub_serial_16bit
    import sub_serial_16bit_pkg::*;
#(
    parameter int LANES = SSUB_LANES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        mode,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic        busy,
    output logic        done,
    output logic [15:0] Diff,
    output logic        V,
    output logic        Z,
    output logic        N
);
    localparam logic [1:0] LAST = 2'(LANES - 1);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        carry_q, carry_d;
    logic        mode_q, mode_d;
    logic [15:0] a_q, a_d, b_q, b_d;
    logic [11:0] part_q, part_d;
    logic        vacc_q, vacc_d;
    logic [15:0] diff_q, diff_d;
    logic        v_q, v_d, z_q, z_d, n_q, n_d;

    logic [3:0]  lane_a, lane_b, lane_diff, lane_sat;
    logic        lane_cin, lane_cout, lane_ovf;
    logic [15:0] res, sat;
    logic        sat_pos, sat_neg;

    assign lane_a   = a_q[{cnt_q, 2'b00} +: 4];
    assign lane_b   = b_q[{cnt_q, 2'b00} +: 4];
    assign lane_cin = mode_q ? 1'b1 : ((cnt_q == 2'd0) ? 1'b1 : carry_q);

    sub_lane_4bit u_lane (
        .a    (lane_a),
        .b    (lane_b),
        .cin  (lane_cin),
        .diff (lane_diff),
        .cout (lane_cout),
        .ovf  (lane_ovf)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        mode_d  = mode_q;
        a_d     = a_q;
        b_d     = b_q;
        part_d  = part_q;
        vacc_d  = vacc_q;
        diff_d  = diff_q;
        v_d     = v_q;
        z_d     = z_q;
        n_d     = n_q;

        // Lane mode saturates per lane; word mode saturates once at the end
        lane_sat = (mode_q && lane_ovf) ? (lane_a[3] ? SAT_NEG4 : SAT_POS4) : lane_diff;
        res      = {lane_sat, part_q};
        sat_pos  = !mode_q && !a_q[15] &&  b_q[15] &&  res[15];
        sat_neg  = !mode_q &&  a_q[15] && !b_q[15] && !res[15];
        sat      = sat_pos ? SAT_POS16 : (sat_neg ? SAT_NEG16 : res);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    mode_d  = mode;
                    cnt_d   = 2'd0;
                    carry_d = 1'b0;
                    vacc_d  = 1'b0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                carry_d = lane_cout;
                vacc_d  = vacc_q | (mode_q & lane_ovf);
                cnt_d   = cnt_q + 2'd1;
                case (cnt_q)
                    2'd0:    part_d[3:0]  = lane_sat;
                    2'd1:    part_d[7:4]  = lane_sat;
                    2'd2:    part_d[11:8] = lane_sat;
                    default: part_d       = part_q;
                endcase
                if (cnt_q == LAST) begin
                    diff_d  = sat;
                    v_d     = sat_pos | sat_neg | vacc_d;
                    z_d     = (sat == 16'h0000);
                    n_d     = sat[15];
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            carry_q <= 1'b0;
            mode_q  <= 1'b0;
            a_q     <= 16'h0000;
            b_q     <= 16'h0000;
            part_q  <= 12'h000;
            vacc_q  <= 1'b0;
            diff_q  <= 16'h0000;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            mode_q  <= mode_d;
            a_q     <= a_d;
            b_q     <= b_d;
            part_q  <= part_d;
            vacc_q  <= vacc_d;
            diff_q  <= diff_d;
            v_q     <= v_d;
            z_q     <= z_d;
            n_q     <= n_d;
        end
    end

    assign busy = (state_q == BUSY);
    assign done = (state_q == DONE);
    assign Diff = diff_q;
    assign V    = v_q;
    assign Z    = z_q;
    assign N    = n_q;
endmodule

// File: tb/tb_sub_serial_16bit.sv
// Scoreboard bench for sub_serial_16bit: directed ops push expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_sub_serial_16bit;
    logic        clk = 1'b0;
    logic        rst_n, start, mode;
    logic [15:0] A, B;
    logic        busy, done, V, Z, N;
    logic [15:0] Diff;

    typedef struct {
        logic [15:0] diff;
        logic        v, z, n;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errs   = 0;
    logic [15:0] hold_d = 16'h0000;

    sub_serial_16bit #(.LANES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .A(A), .B(B),
        .busy(busy), .done(done), .Diff(Diff), .V(V), .Z(Z), .N(N)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("Diff", {16'h0, Diff}, {16'h0, e.diff});
                chk("V", {31'h0, V}, {31'h0, e.v});
                chk("Z", {31'h0, Z}, {31'h0, e.z});
                chk("N", {31'h0, N}, {31'h0, e.n});
            end
        end
    end

    task automatic issue(input logic m, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] ed, input logic ev, input logic ez,
                         input logic en, input bit repulse);
        exp_t e;
        @(negedge clk);
        mode = m; A = a; B = b; start = 1'b1;
        e.diff = ed; e.v = ev; e.z = ez; e.n = en;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0; A = ~a; B = ~b; mode = ~m;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("busy", {31'h0, busy}, 32'd1);
            chk("done_early", {31'h0, done}, 32'd0);
            chk("diff_hold", {16'h0, Diff}, {16'h0, hold_d});
            if (repulse && i == 1) begin
                start = 1'b1; A = 16'hFFFF; B = 16'h0001; mode = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        chk("done_5th_edge", {31'h0, done}, 32'd1);
        chk("busy_off", {31'h0, busy}, 32'd0);
        hold_d = ed;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; A = 16'h0; B = 16'h0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_done", {31'h0, done}, 32'd0);
        chk("rst_Diff", {16'h0, Diff}, 32'd0);
        chk("rst_VZN", {29'h0, V, Z, N}, 32'd0);
        rst_n = 1'b1;

        issue(1'b0, 16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(1'b0, 16'h7FFF, 16'hFFFF, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b0);
        issue(1'b0, 16'h8000, 16'h0001, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b0);
        issue(1'b1, 16'h7830, 16'hF132, 16'h780E, 1'b1, 1'b0, 1'b0, 1'b0);
        issue(1'b0, 16'hABCD, 16'hABCD, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        // Back-to-back: next issue drives start in the IDLE cycle after DONE
        issue(1'b1, 16'h1234, 16'h1111, 16'h0123, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(1'b1, 16'h0000, 16'h0001, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(1'b1, 16'h8000, 16'h1000, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b0);
        issue(1'b0, 16'h0001, 16'h0003, 16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0);
        issue(1'b0, 16'h1000, 16'h0001, 16'h0FFF, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(1'b0, 16'h5000, 16'h1000, 16'h4000, 1'b0, 1'b0, 1'b0, 1'b1);

        // Abort an op after two lanes; nothing is pushed for it
        @(negedge clk);
        mode = 1'b0; A = 16'h1111; B = 16'h0001; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'h0, busy}, 32'd0);
        chk("abort_done", {31'h0, done}, 32'd0);
        chk("abort_Diff", {16'h0, Diff}, 32'd0);
        chk("abort_VZN", {29'h0, V, Z, N}, 32'd0);
        hold_d = 16'h0000;
        @(negedge clk);
        rst_n = 1'b1;
        issue(1'b0, 16'h2222, 16'h0022, 16'h2200, 1'b0, 1'b0, 1'b0, 1'b0);

        repeat (10) @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end
endmodule

// File: doc/sub_serial_16bit.md
SUB_SERIAL_16BIT -- requirements
Module: sub_serial_16bit

Interface
REQ-001 SHALL have parameter LANES, default 4, giving the number of 4-bit lanes per 16-bit operand (fixed at 4; other values unsupported).
REQ-002 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port mode  input  1  0 = 16-bit saturating subtract, 1 = four independent 4-bit saturating lane subtracts.
REQ-006 SHALL have port A  input  16  minuend, two's complement.
REQ-007 SHALL have port B  input  16  subtrahend, two's complement.
REQ-008 SHALL have port busy  output  1  high in BUSY.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port Diff  output  16  saturated result A-B.
REQ-011 SHALL have ports V, Z, N  output  1 each  overflow, zero and negative flags.

Function
REQ-012 SHALL use FSM states IDLE, BUSY, DONE.
REQ-013 SHALL, at the edge sampling start=1 in IDLE, latch A, B and mode, clear lane counter to 0, and enter BUSY.
REQ-014 SHALL ignore start in BUSY and DONE; operands change after capture has no effect.
REQ-015 SHALL process one lane per edge in BUSY, lane k = bits [4k+3:4k], k = counter 0..3, as lane A + ~lane B + cin.
REQ-016 SHALL, in mode 0, use cin=1 for lane 0 and the registered carry-out of lane k-1 for lane k.
REQ-017 SHALL, in mode 1, use cin=1 for every lane, with no carry between lanes.
REQ-018 SHALL, at the edge processing lane 3, enter DONE and update Diff, V, Z and N together.
REQ-019 SHALL hold done=1 for exactly the one cycle in DONE, then return to IDLE.
REQ-020 SHALL give latency: done high in the cycle after the 5th rising edge counted from the start-capture edge (capture + 4 lanes).
REQ-021 SHALL, in mode 0 with A[15]=0, B[15]=1 and raw bit15=1, saturate Diff to 0x7FFF with V=1.
REQ-022 SHALL, in mode 0 with A[15]=1, B[15]=0 and raw bit15=0, saturate Diff to 0x8000 with V=1.
REQ-023 SHALL, in mode 1, saturate each lane independently, positive overflow to 4'h7 and negative to 4'h8, with V = OR of lane overflows.
REQ-024 SHALL set Z = (saturated Diff == 0) and N = saturated Diff[15] in both modes.
REQ-025 SHALL hold Diff, V, Z and N stable from the DONE update until the next DONE update.
REQ-026 SHALL keep partial lane results internal, so Diff never shows a partially computed value.
REQ-027 SHALL accept a start asserted in the IDLE cycle immediately after DONE (back-to-back ops, 6-cycle issue interval).

Reset
REQ-028 SHALL, on rst_n low at any time including mid-operation, force IDLE, counter 0, carry 0 and busy=done=0 immediately.
REQ-029 SHALL, on rst_n low, force Diff=0x0000 and V=Z=N=0, discarding any in-flight operation.
REQ-030 SHALL leave reset synchronously to clk, with the first start sampled at the first rising edge where rst_n=1.

Structure
REQ-031 SHALL take the state encoding, the saturation constants (16'h7FFF, 16'h8000, 4'h7, 4'h8) and LANES from a shared project package/include.
REQ-032 SHALL instantiate one combinational sub-module, sub_lane_4bit (inputs a, b, cin; outputs raw diff, cout, lane overflow), used once per cycle on the selected lane.

Verification
REQ-033 SHALL cover mode 0, A=0x1234, B=0x0234 -> Diff=0x1000, V=0, Z=0, N=0, done exactly 5 edges after capture, busy high 4 cycles.
REQ-034 SHALL cover mode 0, A=0x7FFF, B=0xFFFF -> Diff=0x7FFF, V=1, N=0; and A=0x8000, B=0x0001 -> Diff=0x8000, V=1, N=1.
REQ-035 SHALL cover mode 1, A=0x7830, B=0xF132 -> Diff=0x780E, V=1, Z=0, N=0.
REQ-036 SHALL cover mode 0, A=B=0xABCD -> Diff=0x0000, Z=1, V=0; then an immediate back-to-back start in the IDLE cycle completes correctly.
REQ-037 SHALL cover start re-pulsed with new operands during BUSY -> ignored, and the original result is produced.
REQ-038 SHALL cover rst_n low after 2 lanes -> busy=0, done=0, Diff=0 immediately; a fresh start then completes with the correct result and no done from the aborted op.
